// File: rtl/timer_count_controller_pkg.sv
// Shared timer definitions: controller state encoding, display limits and a
// wrap-around increment helper. Used by the timer FSM, display logic and the
// count controller.
package timer_count_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_SET     = 2'b01,
        ST_RUN     = 2'b10,
        ST_EXPIRED = 2'b11
    } ctrl_state_t;

    localparam int MAX_SECONDS = 59;
    localparam int MAX_MINUTES = 99;

    // Increment that returns to zero once the limit has been reached.
    function automatic logic [6:0] wrap_inc(input logic [6:0] value, input logic [6:0] max_value);
        return (value >= max_value) ? 7'd0 : value + 7'd1;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// One-second tick generator.
// Ports:
//   clk, rst_n  - clock and asynchronous active-low reset
//   clear       - synchronous restart of the period (wins over enable)
//   enable      - advance the period count this cycle
//   tick        - high in the last cycle of a period while enabled
module tick_prescaler #(
    parameter int PRESCALE = 50000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CW = $clog2(PRESCALE);
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] count;

    // Tick is gated by enable so a period frozen on its last count does not
    // keep firing while paused.
    assign tick = enable && (count == LAST);

    // Period counter: holds when disabled, wraps to zero after the tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= tick ? '0 : count + CW'(1);
        end
    end

endmodule

// File: rtl/timer_count_controller.sv
// Minutes/seconds countdown controller with set mode, pause and alarm.
// Ports:
//   clk, rst_n      - clock and asynchronous active-low reset
//   enable_counter  - counter enable from the timer FSM
//   forward         - 1 = setting mode, 0 = countdown mode
//   reset_timer     - synchronous clear of the whole controller
//   seg_demand      - seconds-increment request level (synchronised)
//   min_demand      - minutes-increment request level (synchronised)
//   seconds         - current seconds 0-59
//   minutes         - current minutes 0-99
//   done            - one-cycle pulse on expiry
//   alarm           - high while the alarm interval lasts
//   ctrl_state      - current state encoding
module timer_count_controller
    import timer_count_controller_pkg::*;
#(
    parameter int PRESCALE    = 50000000,
    parameter int ALARM_TICKS = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable_counter,
    input  logic       forward,
    input  logic       reset_timer,
    input  logic       seg_demand,
    input  logic       min_demand,
    output logic [5:0] seconds,
    output logic [6:0] minutes,
    output logic       done,
    output logic       alarm,
    output logic [1:0] ctrl_state
);

    localparam int AW = (ALARM_TICKS > 1) ? $clog2(ALARM_TICKS) : 1;
    localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_TICKS - 1);

    ctrl_state_t   state, state_next;
    logic [5:0]    seconds_next;
    logic [6:0]    minutes_next;
    logic          done_next, alarm_next;
    logic [AW-1:0] alarm_cnt, alarm_cnt_next;
    logic          seg_prev, min_prev;
    logic          seg_rise, min_rise;
    logic [5:0]    sec_dec;
    logic [6:0]    min_dec;
    logic          value_zero, dec_zero;
    logic          tick, presc_clear, presc_enable;

    assign ctrl_state = state;
    assign seg_rise   = seg_demand & ~seg_prev;
    assign min_rise   = min_demand & ~min_prev;
    assign value_zero = (seconds == 6'd0) && (minutes == 7'd0);

    // The prescaler only advances while genuinely counting down or while the
    // alarm is timing out. It is restarted in IDLE/SET, when leaving RUN for
    // SET, and when RUN expires at 00:00 without a tick, so every alarm
    // interval starts on a fresh period.
    assign presc_enable = ((state == ST_RUN) && enable_counter && !forward && !value_zero)
                          || (state == ST_EXPIRED);
    assign presc_clear  = reset_timer || (state == ST_IDLE) || (state == ST_SET)
                          || ((state == ST_RUN) && (value_zero || (enable_counter && forward)));

    tick_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (presc_clear),
        .enable (presc_enable),
        .tick   (tick)
    );

    // One-second decrement of the displayed value, borrowing a minute when
    // the seconds are already zero.
    always_comb begin
        sec_dec = seconds - 6'd1;
        min_dec = minutes;
        if (seconds == 6'd0) begin
            sec_dec = 6'(MAX_SECONDS);
            min_dec = minutes - 7'd1;
        end
        dec_zero = (sec_dec == 6'd0) && (min_dec == 7'd0);
    end

    // Next-state and next-output logic; reset_timer overrides everything.
    always_comb begin
        state_next     = state;
        seconds_next   = seconds;
        minutes_next   = minutes;
        done_next      = 1'b0;
        alarm_next     = alarm;
        alarm_cnt_next = alarm_cnt;

        case (state)
            ST_IDLE: begin
                alarm_next     = 1'b0;
                alarm_cnt_next = '0;
                if (enable_counter) begin
                    state_next = forward ? ST_SET : ST_RUN;
                end
            end
            ST_SET: begin
                if (seg_rise) begin
                    seconds_next = 6'(wrap_inc({1'b0, seconds}, 7'(MAX_SECONDS)));
                end
                if (min_rise) begin
                    minutes_next = wrap_inc(minutes, 7'(MAX_MINUTES));
                end
                if (!enable_counter) begin
                    state_next = ST_IDLE;
                end else if (!forward) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (value_zero) begin
                    state_next     = ST_EXPIRED;
                    done_next      = 1'b1;
                    alarm_next     = 1'b1;
                    alarm_cnt_next = '0;
                end else if (enable_counter && forward) begin
                    state_next = ST_SET;
                end else if (tick) begin
                    seconds_next = sec_dec;
                    minutes_next = min_dec;
                    if (dec_zero) begin
                        state_next     = ST_EXPIRED;
                        done_next      = 1'b1;
                        alarm_next     = 1'b1;
                        alarm_cnt_next = '0;
                    end
                end
            end
            ST_EXPIRED: begin
                alarm_next = 1'b1;
                if (tick) begin
                    if (alarm_cnt == ALARM_LAST) begin
                        state_next     = ST_IDLE;
                        alarm_next     = 1'b0;
                        alarm_cnt_next = '0;
                    end else begin
                        alarm_cnt_next = alarm_cnt + AW'(1);
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (reset_timer) begin
            state_next     = ST_IDLE;
            seconds_next   = '0;
            minutes_next   = '0;
            done_next      = 1'b0;
            alarm_next     = 1'b0;
            alarm_cnt_next = '0;
        end
    end

    // State and output registers, plus the demand edge-detect history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            seconds   <= '0;
            minutes   <= '0;
            done      <= 1'b0;
            alarm     <= 1'b0;
            alarm_cnt <= '0;
            seg_prev  <= 1'b0;
            min_prev  <= 1'b0;
        end else begin
            state     <= state_next;
            seconds   <= seconds_next;
            minutes   <= minutes_next;
            done      <= done_next;
            alarm     <= alarm_next;
            alarm_cnt <= alarm_cnt_next;
            seg_prev  <= seg_demand;
            min_prev  <= min_demand;
        end
    end

endmodule

// File: tb/tb_timer_count_controller.sv
// Self-checking bench for timer_count_controller with PRESCALE=4 and
// ALARM_TICKS=2: a vector table for set mode, directed multi-cycle
// sequences, then random stimulus against a behavioural model.
module tb_timer_count_controller;

    localparam int PRESCALE    = 4;
    localparam int ALARM_TICKS = 2;

    logic       clk;
    logic       rst_n;
    logic       enable_counter;
    logic       forward;
    logic       reset_timer;
    logic       seg_demand;
    logic       min_demand;
    logic [5:0] seconds;
    logic [6:0] minutes;
    logic       done;
    logic       alarm;
    logic [1:0] ctrl_state;

    int checks = 0;
    int errors = 0;

    // Behavioural model: value kept as plain integers, countdown done on the
    // total number of seconds.
    int mState, mSec, mMin, mPresc, mAlarmLeft;
    bit mDone, mAlarm, mSegPrev, mMinPrev;

    typedef struct {
        bit en;
        bit fwd;
        bit rt;
        bit seg;
        bit mn;
        int expSec;
        int expMin;
        int expState;
        bit expDone;
        bit expAlarm;
    } vec_t;

    vec_t vecs[14];

    timer_count_controller #(
        .PRESCALE(PRESCALE),
        .ALARM_TICKS(ALARM_TICKS)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable_counter (enable_counter),
        .forward        (forward),
        .reset_timer    (reset_timer),
        .seg_demand     (seg_demand),
        .min_demand     (min_demand),
        .seconds        (seconds),
        .minutes        (minutes),
        .done           (done),
        .alarm          (alarm),
        .ctrl_state     (ctrl_state)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always ends.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation still running at time %0t, required to finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mkVec(bit en, bit fwd, bit rt, bit seg, bit mn,
                                   int s, int m, int st, bit d, bit a);
        vec_t v;
        v.en = en; v.fwd = fwd; v.rt = rt; v.seg = seg; v.mn = mn;
        v.expSec = s; v.expMin = m; v.expState = st; v.expDone = d; v.expAlarm = a;
        return v;
    endfunction

    task automatic modelReset();
        mState = 0; mSec = 0; mMin = 0; mPresc = 0; mAlarmLeft = 0;
        mDone = 0; mAlarm = 0; mSegPrev = 0; mMinPrev = 0;
    endtask

    task automatic modelExpire();
        mState = 3; mDone = 1; mAlarm = 1; mAlarmLeft = ALARM_TICKS; mPresc = 0;
    endtask

    // One clock edge of the model, using the inputs currently driven.
    task automatic modelStep();
        bit segRise, minRise;
        int total;
        segRise = seg_demand && !mSegPrev;
        minRise = min_demand && !mMinPrev;
        mDone = 0;
        if (reset_timer) begin
            mState = 0; mSec = 0; mMin = 0; mPresc = 0; mAlarm = 0; mAlarmLeft = 0;
        end else begin
            case (mState)
                0: begin
                    mPresc = 0;
                    if (enable_counter) mState = forward ? 1 : 2;
                end
                1: begin
                    mPresc = 0;
                    if (segRise) mSec = (mSec + 1) % 60;
                    if (minRise) mMin = (mMin + 1) % 100;
                    if (!enable_counter) mState = 0;
                    else if (!forward) mState = 2;
                end
                2: begin
                    if (mSec == 0 && mMin == 0) begin
                        modelExpire();
                    end else if (enable_counter && forward) begin
                        mState = 1;
                        mPresc = 0;
                    end else if (enable_counter) begin
                        if (mPresc == PRESCALE - 1) begin
                            mPresc = 0;
                            total = mMin * 60 + mSec - 1;
                            mSec = total % 60;
                            mMin = total / 60;
                            if (total == 0) modelExpire();
                        end else begin
                            mPresc = mPresc + 1;
                        end
                    end
                end
                default: begin
                    mPresc = (mPresc + 1) % PRESCALE;
                    if (mPresc == 0) begin
                        mAlarmLeft = mAlarmLeft - 1;
                        if (mAlarmLeft == 0) begin
                            mState = 0;
                            mAlarm = 0;
                        end
                    end
                end
            endcase
        end
        mSegPrev = seg_demand;
        mMinPrev = min_demand;
    endtask

    // Drive one cycle of inputs, advance the model with the DUT edge, and
    // leave time 1 unit after the edge for sampling.
    task automatic applyStimulus(bit en, bit fwd, bit rt, bit seg, bit mn);
        enable_counter = en;
        forward        = fwd;
        reset_timer    = rt;
        seg_demand     = seg;
        min_demand     = mn;
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic checkOutput(string name, int expSec, int expMin, int expState,
                               bit expDone, bit expAlarm);
        checks++;
        if (seconds !== 6'(expSec) || minutes !== 7'(expMin) || ctrl_state !== 2'(expState)
            || done !== expDone || alarm !== expAlarm) begin
            errors++;
            $display("[TB] FAIL %s: got %0d:%0d state=%0d done=%0b alarm=%0b, expected %0d:%0d state=%0d done=%0b alarm=%0b",
                     name, minutes, seconds, ctrl_state, done, alarm,
                     expMin, expSec, expState, expDone, expAlarm);
        end
    endtask

    task automatic checkValue(string name, int actual, int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Clear, enter SET, then pulse the demands to reach the given value.
    task automatic loadValue(int s, int m);
        applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(1, 1, 0, 0, 0);
        for (int i = 0; i < s; i++) begin
            applyStimulus(1, 1, 0, 1, 0);
            applyStimulus(1, 1, 0, 0, 0);
        end
        for (int i = 0; i < m; i++) begin
            applyStimulus(1, 1, 0, 0, 1);
            applyStimulus(1, 1, 0, 0, 0);
        end
    endtask

    initial begin
        int doneCount;
        int alarmCycles;

        vecs[0]  = mkVec(1, 1, 0, 0, 0, 0, 0, 1, 0, 0);
        vecs[1]  = mkVec(1, 1, 0, 1, 0, 1, 0, 1, 0, 0);
        vecs[2]  = mkVec(1, 1, 0, 0, 0, 1, 0, 1, 0, 0);
        vecs[3]  = mkVec(1, 1, 0, 1, 0, 2, 0, 1, 0, 0);
        vecs[4]  = mkVec(1, 1, 0, 0, 0, 2, 0, 1, 0, 0);
        vecs[5]  = mkVec(1, 1, 0, 1, 0, 3, 0, 1, 0, 0);
        vecs[6]  = mkVec(1, 1, 0, 0, 1, 3, 1, 1, 0, 0);
        vecs[7]  = mkVec(1, 1, 0, 0, 0, 3, 1, 1, 0, 0);
        vecs[8]  = mkVec(1, 1, 0, 0, 1, 3, 2, 1, 0, 0);
        vecs[9]  = mkVec(1, 1, 0, 0, 0, 3, 2, 1, 0, 0);
        vecs[10] = mkVec(0, 1, 0, 0, 0, 3, 2, 0, 0, 0);
        vecs[11] = mkVec(1, 1, 0, 0, 0, 3, 2, 1, 0, 0);
        vecs[12] = mkVec(1, 1, 0, 1, 1, 4, 3, 1, 0, 0);
        vecs[13] = mkVec(1, 1, 0, 0, 0, 4, 3, 1, 0, 0);

        modelReset();
        rst_n = 1'b0;
        enable_counter = 0; forward = 0; reset_timer = 0; seg_demand = 0; min_demand = 0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset state", 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].en, vecs[i].fwd, vecs[i].rt, vecs[i].seg, vecs[i].mn);
            checkOutput($sformatf("set vector %0d", i), vecs[i].expSec, vecs[i].expMin,
                        vecs[i].expState, vecs[i].expDone, vecs[i].expAlarm);
        end

        $display("[TB] held seg_demand");
        repeat (10) applyStimulus(1, 1, 0, 1, 0);
        checkOutput("held seg once", 5, 3, 1, 0, 0);
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("held seg release", 5, 3, 1, 0, 0);

        $display("[TB] wrap at 59/99");
        loadValue(59, 99);
        checkOutput("load 99:59", 59, 99, 1, 0, 0);
        applyStimulus(1, 1, 0, 1, 1);
        checkOutput("both wrap", 0, 0, 1, 0, 0);

        $display("[TB] countdown 01:01");
        loadValue(1, 1);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("enter run", 1, 1, 2, 0, 0);
        doneCount = 0;
        for (int c = 1; c <= 244; c++) begin
            applyStimulus(1, 0, 0, 0, 0);
            if (done) doneCount++;
            if (c == 4)   checkOutput("run 01:00", 0, 1, 2, 0, 0);
            if (c == 8)   checkOutput("run 00:59", 59, 0, 2, 0, 0);
            if (c == 244) checkOutput("expiry", 0, 0, 3, 1, 1);
        end
        alarmCycles = alarm ? 1 : 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(0, 1, 0, i[0], i[0]);
            if (done) doneCount++;
            if (alarm) alarmCycles++;
            else break;
        end
        checkValue("alarm length", alarmCycles, 8);
        checkValue("done pulses", doneCount, 1);
        checkOutput("alarm timeout idle", 0, 0, 0, 0, 0);

        $display("[TB] pause and resume");
        loadValue(5, 0);
        applyStimulus(1, 0, 0, 0, 0);
        repeat (6) applyStimulus(1, 0, 0, 0, 0);
        checkOutput("run 6 cycles", 4, 0, 2, 0, 0);
        repeat (20) applyStimulus(0, 0, 0, 0, 0);
        checkOutput("paused", 4, 0, 2, 0, 0);
        repeat (2) applyStimulus(1, 0, 0, 0, 0);
        checkOutput("resumed", 3, 0, 2, 0, 0);

        $display("[TB] async reset mid-run");
        loadValue(30, 0);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("run 00:30", 30, 0, 2, 0, 0);
        repeat (2) applyStimulus(1, 0, 0, 0, 0);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("async reset", 0, 0, 0, 0, 0);
        modelReset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) applyStimulus(0, 0, 0, 0, 0);
        checkOutput("after reset release", 0, 0, 0, 0, 0);

        $display("[TB] run at 00:00 and reset_timer in EXPIRED");
        applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("run at zero", 0, 0, 2, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("zero expires", 0, 0, 3, 1, 1);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("done one cycle", 0, 0, 3, 0, 1);
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput("reset_timer in expired", 0, 0, 0, 0, 0);

        $display("[TB] random stimulus");
        for (int i = 0; i < 3000; i++) begin
            bit en, fwd, rt, seg, mn;
            en  = ($urandom % 8) != 0;
            fwd = ($urandom % 4) == 0;
            rt  = ($urandom % 64) == 0;
            seg = ($urandom % 2) == 0;
            mn  = ($urandom % 3) == 0;
            applyStimulus(en, fwd, rt, seg, mn);
            checkOutput("random vs model", mSec, mMin, mState, mDone, mAlarm);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/timer_count_controller.md
TIMER_COUNT_CONTROLLER -- requirements
Module: timer_count_controller

Interface
REQ-001 Parameter PRESCALE, default 50000000, clk cycles per one-second tick (SHALL be >= 2).
REQ-002 Parameter ALARM_TICKS, default 5, seconds alarm stays asserted after expiry (SHALL be >= 1).
REQ-003 Port clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port enable_counter  input  1  counter enable from the timer FSM.
REQ-006 Port forward  input  1  1 = setting mode, 0 = countdown mode (valid while enable_counter=1).
REQ-007 Port reset_timer  input  1  synchronous clear request from the timer FSM.
REQ-008 Port seg_demand  input  1  seconds-increment request level, already synchronised to clk.
REQ-009 Port min_demand  input  1  minutes-increment request level, already synchronised to clk.
REQ-010 Port seconds  output  6  current seconds, binary 0-59.
REQ-011 Port minutes  output  7  current minutes, binary 0-99.
REQ-012 Port done  output  1  one-cycle pulse on expiry.
REQ-013 Port alarm  output  1  level, high during alarm interval.
REQ-014 Port ctrl_state  output  2  current internal state encoding.

Function
REQ-015 States SHALL be IDLE=00, SET=01, RUN=10, EXPIRED=11.
REQ-016 reset_timer=1 SHALL, next edge, force IDLE, seconds=0, minutes=0, prescaler=0, alarm=0, done=0, regardless of every other input.
REQ-017 IDLE -> SET when enable_counter=1 and forward=1; IDLE -> RUN when enable_counter=1 and forward=0; else stay.
REQ-018 SET: rising edge of seg_demand (0 in previous cycle, 1 now) SHALL increment seconds, 59 wraps to 0, no carry into minutes.
REQ-019 SET: rising edge of min_demand SHALL increment minutes, 99 wraps to 0.
REQ-020 Simultaneous seg_demand and min_demand rising edges SHALL both apply in the same cycle; a held level SHALL increment once only.
REQ-021 Entering SET SHALL clear the prescaler; SET -> RUN when enable_counter=1 and forward=0; SET -> IDLE when enable_counter=0.
REQ-022 RUN: prescaler SHALL count 0..PRESCALE-1 while enable_counter=1; tick = prescaler at PRESCALE-1, after which it wraps to 0.
REQ-023 RUN with enable_counter=0 (pause) SHALL freeze prescaler, seconds and minutes, stay in RUN; resume continues from the frozen prescaler value.
REQ-024 On tick: seconds>0 -> seconds-1; seconds=0 and minutes>0 -> minutes-1, seconds=59.
REQ-025 The tick that makes the value 00:00 SHALL move to EXPIRED and assert done in the same cycle the registers read 00:00.
REQ-026 Entering RUN with value 00:00 SHALL move to EXPIRED on the next edge with done pulsed for that one cycle, no tick needed.
REQ-027 RUN with forward=1 and enable_counter=1 SHALL move to SET, retaining the current value.
REQ-028 EXPIRED: alarm=1; prescaler keeps running; after ALARM_TICKS ticks alarm=0 and state -> IDLE holding 00:00.
REQ-029 EXPIRED SHALL ignore enable_counter, forward, seg_demand and min_demand; only reset_timer or timeout exits.
REQ-030 done SHALL be high for exactly one cycle per expiry; all outputs registered, no combinational input-to-output path.

Reset
REQ-031 rst_n=0 SHALL asynchronously force IDLE, seconds=0, minutes=0, prescaler=0, alarm counter=0, done=0, alarm=0, edge-detect history=0.
REQ-032 Deassertion of rst_n mid-operation SHALL resume from IDLE with all-zero state; no stale tick or done SHALL follow.

Structure
REQ-033 State encodings, MAX_SECONDS=59 and MAX_MINUTES=99 SHALL live in the shared timer package also used by the timer FSM and display logic.
REQ-034 The prescaler SHALL be one sub-module, tick_prescaler (clear, enable in; tick out), instantiated once.

Verification (PRESCALE=4, ALARM_TICKS=2)
REQ-035 SET, 3 seg_demand pulses, 2 min_demand pulses -> seconds=3, minutes=2; a 10-cycle held seg_demand -> +1 only.
REQ-036 SET at 59 s / 99 min, both demands rise same cycle -> seconds=0, minutes=0, minutes never carried.
REQ-037 Load 01:01, RUN -> 01:00 after 4 cycles, 00:59 after 8, 00:00 after 244 cycles with done high exactly one cycle, alarm high 8 cycles, then ctrl_state=00.
REQ-038 Load 00:05, RUN 6 cycles, enable_counter=0 for 20 cycles -> value frozen at 00:04; resume -> 00:03 after 2 more cycles.
REQ-039 RUN at 00:00 -> EXPIRED next edge, done=1 one cycle.
REQ-040 rst_n pulsed low mid-RUN at 00:30 -> outputs zero immediately (asynchronous), ctrl_state=00; reset_timer during EXPIRED -> alarm=0 next edge.
